// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the game sequencing controller:
//               display-mode codes, FSM state encoding and timer width.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Width of the shared millisecond down-counter (SERVE_MS/POINT_MS <= 4095)
    localparam int TIMER_W = 12;

    // Display-mode codes driven on stateGm
    localparam logic [1:0] GM_BLANK = 2'b00;
    localparam logic [1:0] GM_PLAY  = 2'b01;
    localparam logic [1:0] GM_P1WIN = 2'b10;
    localparam logic [1:0] GM_P2WIN = 2'b11;

    // Game sequencing states, binary encoded
    typedef logic [2:0] game_state_t;

    localparam game_state_t ST_IDLE  = 3'd0;
    localparam game_state_t ST_SERVE = 3'd1;
    localparam game_state_t ST_PLAY  = 3'd2;
    localparam game_state_t ST_POINT = 3'd3;
    localparam game_state_t ST_WIN1  = 3'd4;
    localparam game_state_t ST_WIN2  = 3'd5;

    // Map a game state onto the display mode shown for it
    function automatic logic [1:0] gm_code(input game_state_t st);
        logic [1:0] code;
        case (st)
            ST_SERVE, ST_PLAY, ST_POINT: code = GM_PLAY;
            ST_WIN1:                     code = GM_P1WIN;
            ST_WIN2:                     code = GM_P2WIN;
            default:                     code = GM_BLANK;
        endcase
        return code;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ============================================================================
// Module      : ms_timer
// Description : Loadable down-counter clocked by a 1 ms tick. A load takes
//               priority over a coincident tick, so the delay is exactly
//               load_val full ticks. done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_timer
    import game_pkg::*;
#(
    parameter int WIDTH = TIMER_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // Count register: load wins over tick; the count holds at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule : ms_timer
`default_nettype wire

// File: rtl/game_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_seq_ctrl
// Description : Game sequencing controller for a two-player paddle game.
//               Steps IDLE -> SERVE -> PLAY -> POINT -> (SERVE | WIN1 | WIN2),
//               keeps the scores, holds/reloads the ball and selects the
//               display mode. One shared ms timer paces SERVE and POINT.
// Revision    : 1.0 - initial release
// ============================================================================
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE = 7,
    parameter int SERVE_MS  = 1000,
    parameter int POINT_MS  = 500
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] stateGm,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       ball_hold,
    output logic       ball_load,
    output logic       serve_dir
);

    localparam logic [3:0]         c_WIN_SCORE  = 4'(WIN_SCORE);
    localparam logic [TIMER_W-1:0] c_SERVE_LOAD = TIMER_W'(SERVE_MS);
    localparam logic [TIMER_W-1:0] c_POINT_LOAD = TIMER_W'(POINT_MS);

    game_state_t r_state;
    game_state_t w_next_state;

    logic       r_start_q;
    logic       w_start_evt;

    logic [1:0] r_state_gm;
    logic [3:0] r_score1;
    logic [3:0] r_score2;
    logic       r_serve_dir;
    logic       r_ball_load;

    logic       w_p1_won;
    logic       w_p2_won;
    logic       w_timer_done;
    logic       w_timer_load;
    logic [TIMER_W-1:0] w_timer_val;

    logic       w_ball_hold;
    logic       w_new_game;
    logic       w_point_p1;
    logic       w_point_p2;
    logic       w_reserve;

    // Rising-edge detect; sample resets high so a button held through reset
    // cannot start a game on release.
    assign w_start_evt = start_btn & ~r_start_q;

    // Win checks look at the already-updated registered scores
    assign w_p1_won = (r_score1 == c_WIN_SCORE);
    assign w_p2_won = (r_score2 == c_WIN_SCORE);

    ms_timer #(
        .WIDTH (TIMER_W)
    ) u_ms_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .tick     (clk_1ms),
        .done     (w_timer_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_next_state = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_timer_done) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_left || miss_right) begin
                    w_next_state = ST_POINT;
                end
            end
            ST_POINT: begin
                if (w_p1_won) begin
                    w_next_state = ST_WIN1;
                end else if (w_p2_won) begin
                    w_next_state = ST_WIN2;
                end else if (w_timer_done) begin
                    w_next_state = ST_SERVE;
                end
            end
            ST_WIN1, ST_WIN2: begin
                if (w_start_evt) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output/strobe decode: ball hold level plus the one-cycle event strobes
    // that drive the timer and the score/serve datapath.
    always_comb begin
        w_ball_hold  = 1'b1;
        w_new_game   = 1'b0;
        w_point_p1   = 1'b0;
        w_point_p2   = 1'b0;
        w_reserve    = 1'b0;
        w_timer_load = 1'b0;
        w_timer_val  = c_SERVE_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_new_game   = 1'b1;
                    w_timer_load = 1'b1;
                end
            end
            ST_PLAY: begin
                w_ball_hold = 1'b0;
                if (miss_left || miss_right) begin
                    // A simultaneous miss on both sides is a void point
                    w_point_p1   = miss_right & ~miss_left;
                    w_point_p2   = miss_left & ~miss_right;
                    w_timer_load = 1'b1;
                    w_timer_val  = c_POINT_LOAD;
                end
            end
            ST_POINT: begin
                if (!w_p1_won && !w_p2_won && w_timer_done) begin
                    w_reserve    = 1'b1;
                    w_timer_load = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: scores, serve direction, ball reload and display mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q   <= 1'b1;
            r_state_gm  <= GM_BLANK;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_serve_dir <= 1'b0;
            r_ball_load <= 1'b0;
        end else begin
            r_start_q   <= start_btn;
            r_state_gm  <= gm_code(r_state);
            // Registered so the pulse lands with serve_dir already settled
            r_ball_load <= w_new_game | w_reserve;
            if (w_new_game) begin
                r_score1    <= 4'd0;
                r_score2    <= 4'd0;
                r_serve_dir <= 1'b0;
            end else begin
                if (w_point_p1) begin
                    if (r_score1 != c_WIN_SCORE) begin
                        r_score1 <= r_score1 + 4'd1;
                    end
                    // Loser of the point serves next
                    r_serve_dir <= 1'b1;
                end
                if (w_point_p2) begin
                    if (r_score2 != c_WIN_SCORE) begin
                        r_score2 <= r_score2 + 4'd1;
                    end
                    r_serve_dir <= 1'b0;
                end
            end
        end
    end

    assign stateGm   = r_state_gm;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign ball_hold = w_ball_hold;
    assign ball_load = r_ball_load;
    assign serve_dir = r_serve_dir;

endmodule : game_seq_ctrl
`default_nettype wire

// File: tb/tb_game_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_seq_ctrl
// Description : Directed self-checking bench for game_seq_ctrl at default
//               parameters (WIN_SCORE 7, SERVE_MS 1000, POINT_MS 500).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       clk_1ms;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] stateGm;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_hold;
    logic       ball_load;
    logic       serve_dir;

    int n_checks;
    int n_pass;

    game_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .clk_1ms    (clk_1ms),
        .start_btn  (start_btn),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .stateGm    (stateGm),
        .score1     (score1),
        .score2     (score2),
        .ball_hold  (ball_hold),
        .ball_load  (ball_load),
        .serve_dir  (serve_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue n 1 ms ticks, each a one-cycle pulse followed by one idle cycle
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_1ms = 1'b1;
            step();
            clk_1ms = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++; if (stateGm !== 2'b00) $display("FAIL rst_stateGm got %b exp 00", stateGm); else n_pass++;
        n_checks++; if (score1 !== 4'd0) $display("FAIL rst_score1 got %0d exp 0", score1); else n_pass++;
        n_checks++; if (score2 !== 4'd0) $display("FAIL rst_score2 got %0d exp 0", score2); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL rst_ball_hold got %b exp 1", ball_hold); else n_pass++;
        n_checks++; if (ball_load !== 1'b0) $display("FAIL rst_ball_load got %b exp 0", ball_load); else n_pass++;
        n_checks++; if (serve_dir !== 1'b0) $display("FAIL rst_serve_dir got %b exp 0", serve_dir); else n_pass++;
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_start_serve();
        start_btn = 1'b1;
        step();
        n_checks++; if (ball_load !== 1'b1) $display("FAIL start_ball_load got %b exp 1", ball_load); else n_pass++;
        n_checks++; if (stateGm !== 2'b00) $display("FAIL start_gm_lag got %b exp 00", stateGm); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL start_hold got %b exp 1", ball_hold); else n_pass++;
        step();
        n_checks++; if (ball_load !== 1'b0) $display("FAIL start_load_once got %b exp 0", ball_load); else n_pass++;
        n_checks++; if (stateGm !== 2'b01) $display("FAIL start_gm got %b exp 01", stateGm); else n_pass++;
        ticks(999);
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL serve_hold_999 got %b exp 1", ball_hold); else n_pass++;
        clk_1ms = 1'b1;
        step();
        clk_1ms = 1'b0;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL serve_hold_zero got %b exp 1", ball_hold); else n_pass++;
        step();
        n_checks++; if (ball_hold !== 1'b0) $display("FAIL serve_play got %b exp 0", ball_hold); else n_pass++;
        n_checks++; if (stateGm !== 2'b01) $display("FAIL play_gm got %b exp 01", stateGm); else n_pass++;
    endtask

    task automatic test_point_p1();
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        n_checks++; if (score1 !== 4'd1) $display("FAIL p1_score1 got %0d exp 1", score1); else n_pass++;
        n_checks++; if (serve_dir !== 1'b1) $display("FAIL p1_serve_dir got %b exp 1", serve_dir); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL p1_hold got %b exp 1", ball_hold); else n_pass++;
        n_checks++; if (ball_load !== 1'b0) $display("FAIL p1_no_load got %b exp 0", ball_load); else n_pass++;
        ticks(499);
        n_checks++; if (ball_load !== 1'b0) $display("FAIL p1_load_early got %b exp 0", ball_load); else n_pass++;
        ticks(1);
        n_checks++; if (ball_load !== 1'b1) $display("FAIL p1_reload got %b exp 1", ball_load); else n_pass++;
        n_checks++; if (serve_dir !== 1'b1) $display("FAIL p1_dir_at_load got %b exp 1", serve_dir); else n_pass++;
        ticks(999);
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL p1_serve_hold got %b exp 1", ball_hold); else n_pass++;
        ticks(1);
        n_checks++; if (ball_hold !== 1'b0) $display("FAIL p1_back_play got %b exp 0", ball_hold); else n_pass++;
    endtask

    task automatic test_p2_wins();
        for (int i = 1; i <= 7; i++) begin
            miss_left = 1'b1;
            step();
            miss_left = 1'b0;
            n_checks++; if (score2 !== 4'(i)) $display("FAIL p2_score2_%0d got %0d exp %0d", i, score2, i); else n_pass++;
            if (i < 7) begin
                ticks(1500);
            end
        end
        n_checks++; if (serve_dir !== 1'b0) $display("FAIL p2_serve_dir got %b exp 0", serve_dir); else n_pass++;
        step();
        step();
        n_checks++; if (stateGm !== 2'b11) $display("FAIL p2_win_gm got %b exp 11", stateGm); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL p2_win_hold got %b exp 1", ball_hold); else n_pass++;
        miss_left  = 1'b1;
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        step();
        miss_left = 1'b0;
        ticks(600);
        n_checks++; if (score1 !== 4'd1) $display("FAIL p2_frozen_s1 got %0d exp 1", score1); else n_pass++;
        n_checks++; if (score2 !== 4'd7) $display("FAIL p2_frozen_s2 got %0d exp 7", score2); else n_pass++;
        n_checks++; if (stateGm !== 2'b11) $display("FAIL p2_no_timeout got %b exp 11", stateGm); else n_pass++;
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        step();
        n_checks++; if (stateGm !== 2'b00) $display("FAIL p2_to_idle got %b exp 00", stateGm); else n_pass++;
        n_checks++; if (ball_load !== 1'b0) $display("FAIL p2_idle_no_load got %b exp 0", ball_load); else n_pass++;
        start_btn = 1'b0;
        step();
    endtask

    task automatic test_double_miss();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        n_checks++; if (score2 !== 4'd0) $display("FAIL dm_clear_s2 got %0d exp 0", score2); else n_pass++;
        ticks(1000);
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        ticks(1500);
        n_checks++; if (ball_hold !== 1'b0) $display("FAIL dm_pre_play got %b exp 0", ball_hold); else n_pass++;
        miss_left  = 1'b1;
        miss_right = 1'b1;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        n_checks++; if (score1 !== 4'd1) $display("FAIL dm_score1 got %0d exp 1", score1); else n_pass++;
        n_checks++; if (score2 !== 4'd0) $display("FAIL dm_score2 got %0d exp 0", score2); else n_pass++;
        n_checks++; if (serve_dir !== 1'b1) $display("FAIL dm_serve_dir got %b exp 1", serve_dir); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL dm_point_hold got %b exp 1", ball_hold); else n_pass++;
        ticks(499);
        n_checks++; if (ball_load !== 1'b0) $display("FAIL dm_load_early got %b exp 0", ball_load); else n_pass++;
        ticks(1);
        n_checks++; if (ball_load !== 1'b1) $display("FAIL dm_reload got %b exp 1", ball_load); else n_pass++;
        n_checks++; if (serve_dir !== 1'b1) $display("FAIL dm_dir_at_load got %b exp 1", serve_dir); else n_pass++;
        ticks(1000);
        n_checks++; if (ball_hold !== 1'b0) $display("FAIL dm_back_play got %b exp 0", ball_hold); else n_pass++;
    endtask

    task automatic test_held_start();
        int loads;
        loads = 0;
        reset     = 1'b1;
        start_btn = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ball_load === 1'b1) loads++;
        end
        n_checks++; if (loads !== 0) $display("FAIL held_loads got %0d exp 0", loads); else n_pass++;
        n_checks++; if (stateGm !== 2'b00) $display("FAIL held_gm got %b exp 00", stateGm); else n_pass++;
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        n_checks++; if (ball_load !== 1'b1) $display("FAIL held_repress_load got %b exp 1", ball_load); else n_pass++;
        step();
        n_checks++; if (stateGm !== 2'b01) $display("FAIL held_repress_gm got %b exp 01", stateGm); else n_pass++;
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        start_btn  = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        n_checks++; if (score1 !== 4'd0) $display("FAIL serve_miss_ignored got %0d exp 0", score1); else n_pass++;
        n_checks++; if (ball_load !== 1'b0) $display("FAIL serve_start_ignored got %b exp 0", ball_load); else n_pass++;
    endtask

    task automatic test_reset_mid_point();
        ticks(1000);
        for (int k = 1; k <= 4; k++) begin
            miss_right = 1'b1;
            step();
            miss_right = 1'b0;
            if (k < 4) begin
                ticks(1500);
            end
        end
        n_checks++; if (score1 !== 4'd4) $display("FAIL mid_pre_score1 got %0d exp 4", score1); else n_pass++;
        step();
        step();
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (stateGm !== 2'b00) $display("FAIL async_gm got %b exp 00", stateGm); else n_pass++;
        n_checks++; if (score1 !== 4'd0) $display("FAIL async_score1 got %0d exp 0", score1); else n_pass++;
        n_checks++; if (score2 !== 4'd0) $display("FAIL async_score2 got %0d exp 0", score2); else n_pass++;
        n_checks++; if (ball_hold !== 1'b1) $display("FAIL async_hold got %b exp 1", ball_hold); else n_pass++;
        n_checks++; if (ball_load !== 1'b0) $display("FAIL async_load got %b exp 0", ball_load); else n_pass++;
        n_checks++; if (serve_dir !== 1'b0) $display("FAIL async_serve_dir got %b exp 0", serve_dir); else n_pass++;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        clk_1ms    = 1'b0;
        start_btn  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        test_reset();
        test_start_serve();
        test_point_p1();
        test_p2_wins();
        test_double_miss();
        test_held_start();
        test_reset_mid_point();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_game_seq_ctrl
`default_nettype wire
